// File: rtl/mcs4_bus_master_if.sv
// Host command/response and MCS-4 bus signals of the mcs4 bus initiator.
// cmd_valid/cmd_ready: the host raises cmd_valid with stable fields and keeps them until it sees cmd_ready;
// the command is taken on the edge that opens A1, cmd_ready marks that first tick, and fields may change after it.
interface mcs4_bus_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [11:0] cmd_addr;
   logic [1:0]  cmd_bank;
   logic [3:0]  cmd_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        sync_out;
   logic        cmrom_out;
   logic [3:0]  cmram_out;
   logic [3:0]  data_out;
   logic        data_oe;
   logic [3:0]  data_in;
   logic [2:0]  dbg_phase;
   logic        dbg_active;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_bank, cmd_wdata, data_in,
      output cmd_ready, rsp_valid, rsp_data, sync_out, cmrom_out, cmram_out,
             data_out, data_oe, dbg_phase, dbg_active
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_bank, cmd_wdata, data_in,
      input  cmd_ready, rsp_valid, rsp_data, sync_out, cmrom_out, cmram_out,
             data_out, data_oe, dbg_phase, dbg_active
   );
endinterface

// File: rtl/mcs4_bus_master.sv
// MCS-4 bus initiator: free-running 8-phase instruction cycle carrying host FETCH/SRC/WRM/RDM commands.
// All bus outputs are registered from the next-tick state, so each drive is stable for its whole phase.
module mcs4_bus_master #(
   parameter int PHASE_TICKS = 27
) (
   input logic sysclk,
   input logic poc,
   mcs4_bus_master_if.master bus
);
   localparam int TW = (PHASE_TICKS > 2) ? $clog2(PHASE_TICKS) : 1;
   localparam logic [TW-1:0] LAST_TICK = TW'(PHASE_TICKS - 1);
   localparam logic [1:0] OP_FETCH = 2'd0;
   localparam logic [1:0] OP_SRC   = 2'd1;
   localparam logic [1:0] OP_WRM   = 2'd2;
   localparam logic [1:0] OP_RDM   = 2'd3;

   typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

   phase_t      phase, n_phase;
   logic [TW-1:0] tick, n_tick;
   logic        active, n_active;
   logic [1:0]  op, n_op;
   logic [11:0] addr, n_addr;
   logic [1:0]  bank, n_bank;
   logic [3:0]  wdata, n_wdata;
   logic [7:0]  rd_buf;
   logic        wrap, start;
   logic        d_oe, d_cmrom, d_sync;
   logic [3:0]  d_out, d_cmram, bank_sel;

   assign bus.dbg_phase  = phase;
   assign bus.dbg_active = active;

   always_comb begin
      wrap     = (tick == LAST_TICK);
      start    = wrap && (phase == X3);
      n_tick   = wrap ? '0 : tick + 1'b1;
      n_phase  = wrap ? phase_t'(phase + 3'd1) : phase;
      n_active = start ? bus.cmd_valid : active;
      n_op     = start ? bus.cmd_op    : op;
      n_addr   = start ? bus.cmd_addr  : addr;
      n_bank   = start ? bus.cmd_bank  : bank;
      n_wdata  = start ? bus.cmd_wdata : wdata;
      bank_sel = 4'b0001 << n_bank;
      d_oe     = 1'b0;
      d_out    = 4'h0;
      d_cmrom  = 1'b0;
      d_cmram  = 4'h0;
      d_sync   = (n_phase == X3);
      // Drives are decoded for the tick about to start, then registered.
      if (n_active) begin
         case (n_phase)
            A1: begin d_oe = 1'b1; d_out = (n_op == OP_FETCH) ? n_addr[3:0]  : 4'h0; end
            A2: begin d_oe = 1'b1; d_out = (n_op == OP_FETCH) ? n_addr[7:4]  : 4'h0; end
            A3: begin
               d_oe    = 1'b1;
               d_out   = (n_op == OP_FETCH) ? n_addr[11:8] : 4'h0;
               d_cmrom = (n_op == OP_FETCH);
            end
            M1: if (n_op != OP_FETCH) begin
               d_oe  = 1'b1;
               d_out = (n_op == OP_SRC) ? 4'h2 : 4'hE;
            end
            M2: case (n_op)
               OP_SRC: begin d_oe = 1'b1; d_out = 4'h1; end
               OP_WRM: begin d_oe = 1'b1; d_out = 4'h0; d_cmram = bank_sel; end
               OP_RDM: begin d_oe = 1'b1; d_out = 4'h9; d_cmram = bank_sel; end
               default: ;
            endcase
            X2: case (n_op)
               OP_SRC: begin d_oe = 1'b1; d_out = n_addr[7:4]; d_cmram = bank_sel; end
               OP_WRM: begin d_oe = 1'b1; d_out = n_wdata; end
               default: ;
            endcase
            X3: if (n_op == OP_SRC) begin d_oe = 1'b1; d_out = n_addr[3:0]; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (poc) begin
         phase         <= A1;
         tick          <= '0;
         active        <= 1'b0;
         op            <= OP_FETCH;
         addr          <= 12'h000;
         bank          <= 2'd0;
         wdata         <= 4'h0;
         rd_buf        <= 8'h00;
         bus.cmd_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= 8'h00;
         bus.sync_out  <= 1'b0;
         bus.cmrom_out <= 1'b0;
         bus.cmram_out <= 4'h0;
         bus.data_out  <= 4'h0;
         bus.data_oe   <= 1'b0;
      end else begin
         phase         <= n_phase;
         tick          <= n_tick;
         active        <= n_active;
         op            <= n_op;
         addr          <= n_addr;
         bank          <= n_bank;
         wdata         <= n_wdata;
         bus.cmd_ready <= start && bus.cmd_valid;
         bus.sync_out  <= d_sync;
         bus.cmrom_out <= d_cmrom;
         bus.cmram_out <= d_cmram;
         bus.data_out  <= d_out;
         bus.data_oe   <= d_oe;
         // Responder nibbles are taken on the last tick of their phase.
         if (active && wrap) begin
            case (phase)
               M1: if (op == OP_FETCH) rd_buf[7:4] <= bus.data_in;
               M2: if (op == OP_FETCH) rd_buf[3:0] <= bus.data_in;
               X2: if (op == OP_RDM)   rd_buf      <= {4'h0, bus.data_in};
               default: ;
            endcase
         end
         bus.rsp_valid <= start && active && ((op == OP_FETCH) || (op == OP_RDM));
         if (start && active && ((op == OP_FETCH) || (op == OP_RDM))) bus.rsp_data <= rd_buf;
      end
   end
endmodule

// File: tb/tb_mcs4_bus_master.sv
// Bench for mcs4_bus_master with small i4001/i4002 responder models tracking the bus phase from SYNC.
module tb_mcs4_bus_master;
   localparam int P = 27;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [1:0]  bank;
      logic [3:0]  wdata;
      logic        exp_rsp;
      logic [7:0]  exp_data;
      logic [7:0]  exp_oe;
      logic [31:0] exp_dout;
      logic [7:0]  exp_cmrom;
      logic [7:0]  exp_cmram_ph;
      logic [3:0]  exp_cmram;
   } vec_t;

   logic sysclk = 1'b0;
   logic poc = 1'b1;
   mcs4_bus_master_if bus();

   mcs4_bus_master #(.PHASE_TICKS(P)) dut (
      .sysclk(sysclk),
      .poc(poc),
      .bus(bus)
   );

   always #25 sysclk = ~sysclk;

   int checks = 0;
   int failures = 0;
   int hold_err = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] rom_val(input logic [11:0] a);
      return (a == 12'h3A5) ? 8'hD7 : (a[7:0] ^ 8'h5A);
   endfunction

   // Responder models and per-phase bus observer
   int m_phase = 0;
   int m_tick = 0;
   bit m_sync = 0, sync_prev = 0;
   bit rom_sel = 0, wr_pend = 0, rd_pend = 0, src_pend = 0;
   logic [3:0] nib[8];
   logic [11:0] rom_a = 12'h000;
   logic [3:0] src_hi = 4'h0;
   logic [7:0] ptr = 8'h00;
   logic [3:0] ram[256];
   logic [7:0] rv;
   logic [10:0] prev_vec = '0, cur_vec;
   logic [7:0] obs_oe = '0, obs_cmrom = '0;
   logic [31:0] obs_dout = '0;
   logic [3:0] obs_cmram[8];

   always @(negedge sysclk) begin
      if (poc) begin
         m_sync = 0; sync_prev = 0;
         rom_sel = 0; wr_pend = 0; rd_pend = 0; src_pend = 0;
         bus.data_in = 4'h0;
      end else begin
         if (bus.sync_out && !sync_prev) begin
            m_phase = 7; m_tick = 0; m_sync = 1;
         end else if (m_tick == P - 1) begin
            m_tick = 0; m_phase = (m_phase + 1) % 8;
         end else begin
            m_tick++;
         end
         sync_prev = bus.sync_out;
         if (m_sync) begin
            cur_vec = {bus.data_oe, bus.data_out, bus.cmrom_out, bus.cmram_out, bus.sync_out};
            if (m_tick != 0 && cur_vec != prev_vec) hold_err++;
            prev_vec = cur_vec;
            if (m_tick == 1) begin
               obs_oe[m_phase] = bus.data_oe;
               obs_dout[m_phase*4 +: 4] = bus.data_oe ? bus.data_out : 4'h0;
               obs_cmrom[m_phase] = bus.cmrom_out;
               obs_cmram[m_phase] = bus.cmram_out;
            end
            rv = rom_val(rom_a);
            if (rom_sel && m_phase == 3) bus.data_in = rv[7:4];
            else if (rom_sel && m_phase == 4) bus.data_in = rv[3:0];
            else if (rd_pend && m_phase == 6) bus.data_in = ram[ptr];
            else bus.data_in = 4'h0;
            if (m_tick == P - 1) begin
               case (m_phase)
                  0, 1, 3: nib[m_phase] = bus.data_out;
                  2: if (bus.cmrom_out) begin
                     rom_a = {bus.data_out, nib[1], nib[0]};
                     rom_sel = 1;
                  end
                  4: begin
                     rom_sel = 0;
                     if (bus.cmram_out[1]) begin
                        if ({nib[3], bus.data_out} == 8'hE0) wr_pend = 1;
                        else if ({nib[3], bus.data_out} == 8'hE9) rd_pend = 1;
                     end
                  end
                  6: begin
                     if (bus.cmram_out[1]) begin
                        src_hi = bus.data_out; src_pend = 1;
                     end else if (wr_pend) begin
                        ram[ptr] = bus.data_out;
                     end
                     wr_pend = 0; rd_pend = 0;
                  end
                  7: if (src_pend) begin
                     ptr = {src_hi, bus.data_out}; src_pend = 0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   vec_t vt[7];
   logic [11:0] b2b_addr[4];

   initial begin
      int n, rsp_cnt, rsp_k, first_sync, sync_hi, busy, acc, last_acc;
      bit got;
      logic [7:0] rsp_got, act_ph;
      logic [3:0] act_or;

      for (int i = 0; i < 256; i++) ram[i] = 4'h0;
      bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_bank = 0; bus.cmd_wdata = 0;

      //        op    addr     bk wd   rsp data   oe     dout          cmrom  cmram_ph cmram
      vt[0] = '{2'd0, 12'h3A5, 2'd0, 4'h0, 1'b1, 8'hD7, 8'h07, 32'h0000_03A5, 8'h04, 8'h00, 4'h0};
      vt[1] = '{2'd1, 12'h04C, 2'd1, 4'h0, 1'b0, 8'h00, 8'hDF, 32'hC401_2000, 8'h00, 8'h40, 4'h2};
      vt[2] = '{2'd2, 12'h000, 2'd1, 4'h9, 1'b0, 8'h00, 8'h5F, 32'h0900_E000, 8'h00, 8'h10, 4'h2};
      vt[3] = '{2'd1, 12'h04C, 2'd1, 4'h0, 1'b0, 8'h00, 8'hDF, 32'hC401_2000, 8'h00, 8'h40, 4'h2};
      vt[4] = '{2'd3, 12'h000, 2'd1, 4'h0, 1'b1, 8'h09, 8'h1F, 32'h0009_E000, 8'h00, 8'h10, 4'h2};
      vt[5] = '{2'd0, 12'h812, 2'd0, 4'h0, 1'b1, 8'h48, 8'h07, 32'h0000_0812, 8'h04, 8'h00, 4'h0};
      vt[6] = '{2'd1, 12'h010, 2'd2, 4'h0, 1'b0, 8'h00, 8'hDF, 32'h0101_2000, 8'h00, 8'h40, 4'h4};

      // Reset and idle cycles
      repeat (3) @(negedge sysclk);
      check("reset_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.sync_out, bus.cmrom_out,
                              bus.cmram_out, bus.data_out, bus.data_oe}, 32'h0);
      poc = 0;
      sync_hi = 0; busy = 0; first_sync = -1;
      for (int k = 1; k <= 24 * P; k++) begin
         @(negedge sysclk);
         if (bus.sync_out) begin
            sync_hi++;
            if (first_sync < 0) first_sync = k;
         end
         if (bus.cmd_ready || bus.rsp_valid || bus.cmrom_out || bus.cmram_out != 0 || bus.data_oe) busy++;
      end
      check("idle_sync_ticks", sync_hi, 3 * P);
      check("idle_first_sync", first_sync, 7 * P);
      check("idle_quiet", busy, 0);

      // Table-driven single commands
      for (int v = 0; v < 7; v++) begin
         bus.cmd_op = vt[v].op; bus.cmd_addr = vt[v].addr;
         bus.cmd_bank = vt[v].bank; bus.cmd_wdata = vt[v].wdata;
         bus.cmd_valid = 1;
         got = 0;
         for (int k = 0; k < 9 * P && !got; k++) begin
            @(negedge sysclk);
            if (bus.cmd_ready) got = 1;
         end
         bus.cmd_valid = 0;
         check($sformatf("v%0d_ready", v), got, 1);
         rsp_cnt = 0; rsp_k = 0; rsp_got = 8'h00;
         for (int k = 1; k <= 8 * P; k++) begin
            @(negedge sysclk);
            if (bus.rsp_valid) begin
               rsp_cnt++; rsp_k = k; rsp_got = bus.rsp_data;
            end
         end
         act_ph = '0; act_or = '0;
         for (int i = 0; i < 8; i++) begin
            act_ph[i] = (obs_cmram[i] != 4'h0);
            act_or |= obs_cmram[i];
         end
         check($sformatf("v%0d_rsp_count", v), rsp_cnt, {31'd0, vt[v].exp_rsp});
         if (vt[v].exp_rsp) begin
            check($sformatf("v%0d_rsp_data", v), rsp_got, vt[v].exp_data);
            check($sformatf("v%0d_rsp_time", v), rsp_k, 8 * P);
         end
         check($sformatf("v%0d_oe", v), obs_oe, vt[v].exp_oe);
         check($sformatf("v%0d_dout", v), obs_dout, vt[v].exp_dout);
         check($sformatf("v%0d_cmrom", v), obs_cmrom, vt[v].exp_cmrom);
         check($sformatf("v%0d_cmram_phase", v), act_ph, vt[v].exp_cmram_ph);
         check($sformatf("v%0d_cmram_line", v), act_or, vt[v].exp_cmram);
      end
      check("i4002_char_4c", ram[8'h4C], 4'h9);

      // Back-to-back FETCHes with cmd_valid held high
      b2b_addr[0] = 12'h123; b2b_addr[1] = 12'h456; b2b_addr[2] = 12'h789; b2b_addr[3] = 12'hABC;
      exp_q.push_back(8'h79); exp_q.push_back(8'h0C); exp_q.push_back(8'hD3); exp_q.push_back(8'hE6);
      bus.cmd_op = 2'd0; bus.cmd_addr = b2b_addr[0]; bus.cmd_valid = 1;
      acc = 0; last_acc = 0; rsp_cnt = 0;
      for (int k = 1; k <= 48 * P && rsp_cnt < 4; k++) begin
         @(negedge sysclk);
         if (bus.cmd_ready) begin
            if (acc > 0) check($sformatf("b2b_gap%0d", acc), k - last_acc, 8 * P);
            last_acc = k;
            acc++;
            if (acc < 4) bus.cmd_addr = b2b_addr[acc];
            else bus.cmd_valid = 0;
         end
         if (bus.rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() > 0) check($sformatf("b2b_rsp%0d", rsp_cnt), bus.rsp_data, exp_q.pop_front());
         end
      end
      bus.cmd_valid = 0;
      check("b2b_accepts", acc, 4);
      check("b2b_rsp_count", rsp_cnt, 4);

      // Reset during M1 of a FETCH
      bus.cmd_op = 2'd0; bus.cmd_addr = 12'h3A5; bus.cmd_valid = 1;
      got = 0;
      for (int k = 0; k < 9 * P && !got; k++) begin
         @(negedge sysclk);
         if (bus.cmd_ready) got = 1;
      end
      bus.cmd_valid = 0;
      check("poc_fetch_ready", got, 1);
      repeat (3 * P + 5) @(negedge sysclk);
      poc = 1;
      @(negedge sysclk);
      check("poc_outputs_zero", {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.sync_out, bus.cmrom_out,
                                 bus.cmram_out, bus.data_out, bus.data_oe}, 32'h0);
      poc = 0;
      bus.cmd_addr = 12'h812; bus.cmd_valid = 1;
      n = -1; rsp_cnt = 0;
      for (int k = 1; k <= 10 * P && n < 0; k++) begin
         @(negedge sysclk);
         if (bus.rsp_valid) rsp_cnt++;
         if (bus.cmd_ready) n = k;
      end
      bus.cmd_valid = 0;
      check("poc_no_rsp", rsp_cnt, 0);
      check("poc_first_accept", n, 8 * P);
      rsp_got = 8'h00; rsp_cnt = 0;
      for (int k = 1; k <= 8 * P; k++) begin
         @(negedge sysclk);
         if (bus.rsp_valid) begin
            rsp_cnt++; rsp_got = bus.rsp_data;
         end
      end
      check("poc_next_rsp_count", rsp_cnt, 1);
      check("poc_next_rsp_data", rsp_got, 8'h48);
      check("drive_hold", hold_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
